// File: rtl/piso_tx.sv
// Byte-to-serial framer: valid/ready byte input, one bit per cycle out, LSB first,
// with a one-byte look-ahead slot. Define PISO_TAIL_FLUSH_EN to append TAIL_BITS zero bits per frame.
module piso_tx #(
  parameter int unsigned TAIL_BITS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_parallel_i,
  input  logic       byte_valid_i,
  input  logic       byte_last_i,
  output logic       byte_ready_o,
  output logic       data_serial_o,
  output logic       valid_serial_o,
  input  logic       serial_ready_i,
  output logic       serial_last_o,
  output logic       busy_o
);

  if (TAIL_BITS == 0 || TAIL_BITS > 15) begin : g_bad_tail
    $error("piso_tx: TAIL_BITS must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2
  } state_e;

  state_e     state, state_n;
  logic [7:0] shift_reg, shift_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       act_last, act_last_n;
  logic [7:0] pend_data, pend_data_n;
  logic       pend_valid, pend_valid_n;
  logic       pend_last, pend_last_n;
  logic       accept, consume;
  logic       load_in, load_pend, to_pend;
  logic       data_n, last_n;

`ifdef PISO_TAIL_FLUSH_EN
  localparam int unsigned TCW = $clog2(TAIL_BITS + 1);
  logic [TCW-1:0] tail_cnt, tail_cnt_n;
`endif

  assign accept  = byte_valid_i && !pend_valid;
  assign consume = (state != ST_IDLE) && serial_ready_i;

  // Next-state: decide where an accepted byte lands and when ACTIVE reloads.
  always_comb begin
    state_n      = state;
    shift_n      = shift_reg;
    bit_cnt_n    = bit_cnt;
    act_last_n   = act_last;
    pend_data_n  = pend_data;
    pend_valid_n = pend_valid;
    pend_last_n  = pend_last;
`ifdef PISO_TAIL_FLUSH_EN
    tail_cnt_n   = tail_cnt;
`endif
    load_in      = 1'b0;
    load_pend    = 1'b0;
    to_pend      = accept;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          load_in = 1'b1;
          to_pend = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (consume) begin
          if (bit_cnt == 3'd7) begin
`ifdef PISO_TAIL_FLUSH_EN
            if (act_last) begin
              state_n    = ST_TAIL;
              tail_cnt_n = '0;
            end else
`endif
            if (pend_valid) begin
              load_pend = 1'b1;
            end else if (accept) begin
              load_in = 1'b1;
              to_pend = 1'b0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            shift_n   = {1'b0, shift_reg[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
`ifdef PISO_TAIL_FLUSH_EN
      ST_TAIL: begin
        if (consume) begin
          if (tail_cnt == TCW'(TAIL_BITS - 1)) begin
            if (pend_valid) begin
              load_pend = 1'b1;
            end else if (accept) begin
              load_in = 1'b1;
              to_pend = 1'b0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            tail_cnt_n = tail_cnt + TCW'(1);
          end
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase

    // accept implies PENDING was empty, so load_pend and to_pend never coincide
    if (load_pend) begin
      shift_n      = pend_data;
      bit_cnt_n    = 3'd0;
      act_last_n   = pend_last;
      state_n      = ST_SHIFT;
      pend_valid_n = 1'b0;
    end
    if (load_in) begin
      shift_n    = data_parallel_i;
      bit_cnt_n  = 3'd0;
      act_last_n = byte_last_i;
      state_n    = ST_SHIFT;
    end
    if (to_pend) begin
      pend_data_n  = data_parallel_i;
      pend_last_n  = byte_last_i;
      pend_valid_n = 1'b1;
    end

    data_n = (state_n == ST_SHIFT) && shift_n[0];
`ifdef PISO_TAIL_FLUSH_EN
    last_n = (state_n == ST_TAIL) && (tail_cnt_n == TCW'(TAIL_BITS - 1));
`else
    last_n = (state_n == ST_SHIFT) && (bit_cnt_n == 3'd7) && act_last_n;
`endif
  end

  // State and registered outputs, all derived from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      act_last       <= 1'b0;
      pend_data      <= '0;
      pend_valid     <= 1'b0;
      pend_last      <= 1'b0;
`ifdef PISO_TAIL_FLUSH_EN
      tail_cnt       <= '0;
`endif
      byte_ready_o   <= 1'b1;
      data_serial_o  <= 1'b0;
      valid_serial_o <= 1'b0;
      serial_last_o  <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state          <= state_n;
      shift_reg      <= shift_n;
      bit_cnt        <= bit_cnt_n;
      act_last       <= act_last_n;
      pend_data      <= pend_data_n;
      pend_valid     <= pend_valid_n;
      pend_last      <= pend_last_n;
`ifdef PISO_TAIL_FLUSH_EN
      tail_cnt       <= tail_cnt_n;
`endif
      byte_ready_o   <= !pend_valid_n;
      data_serial_o  <= data_n;
      valid_serial_o <= (state_n != ST_IDLE);
      serial_last_o  <= last_n;
      busy_o         <= (state_n != ST_IDLE) || pend_valid_n;
    end
  end

endmodule
